// File: rtl/flow_pkg.sv
// flow_pkg: shared types, lane-order constants and parameter helpers for the flow library
package flow_pkg;
  localparam logic LANE_LSB_FIRST = 1'b0;
  localparam logic LANE_MSB_FIRST = 1'b1;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic bit params_ok(input int dst_w, input int ratio);
    return (dst_w >= 1) && (ratio >= 2);
  endfunction
endpackage

// File: rtl/flow_lane_sel.sv
// flow_lane_sel: combinational N:1 lane mux selecting a W-bit lane from a packed word
module flow_lane_sel #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [W*N-1:0] hold_i,
  input  logic [IW-1:0]  idx_i,
  output logic [W-1:0]   lane_o
);
  always_comb begin
    lane_o = '0;
    for (int i = 0; i < N; i++) lane_o = (idx_i == IW'(i)) ? hold_i[i*W +: W] : lane_o;
  end
endmodule

// File: rtl/flow_wide2narrow.sv
// flow_wide2narrow: splits a DST_W*RATIO valid-ready word into DST_W lanes with selectable order
module flow_wide2narrow
  import flow_pkg::*;
#(
  parameter  int DST_W = 8,
  parameter  int RATIO = 4,
  localparam int IW    = clog2_min1(RATIO),
  localparam int SRC_W = DST_W * RATIO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic             cfg_msb_first,
  input  logic             src_val,
  output logic             src_rdy,
  input  logic [SRC_W-1:0] src_data,
  input  logic [IW-1:0]    src_nlanes,
  output logic             dst_val,
  input  logic             dst_rdy,
  output logic [DST_W-1:0] dst_data,
  output logic             dst_last,
  output logic             busy
);
  if (!params_ok(DST_W, RATIO)) begin : g_bad_params
    $error("flow_wide2narrow: RATIO must be >= 2 and DST_W >= 1");
  end
  localparam logic [IW-1:0] NL_MAX = IW'(RATIO - 1);
  state_t             state_q;
  logic [SRC_W-1:0]   hold_q;
  logic [IW-1:0]      cnt_q, nl_q, nl_d, idx;
  logic               ord_q, src_acc;
  logic [DST_W-1:0]   lane;
  assign dst_val  = (state_q == SEND);
  assign busy     = dst_val;
  assign dst_last = dst_val & (cnt_q == nl_q);
  // a new word may enter in the same cycle the final lane of the current one leaves
  assign src_rdy  = rst_n & cfg_en & (~dst_val | (dst_rdy & dst_last));
  assign src_acc  = src_val & src_rdy;
  assign nl_d     = (src_nlanes >= NL_MAX) ? NL_MAX : src_nlanes;
  assign idx      = (ord_q == LANE_MSB_FIRST) ? nl_q - cnt_q : cnt_q;
  flow_lane_sel #(.W(DST_W), .N(RATIO), .IW(IW)) u_lane_sel (
    .hold_i (hold_q),
    .idx_i  (idx),
    .lane_o (lane)
  );
  assign dst_data = dst_val ? lane : '0;
  always_ff @(posedge clk) begin
    if (!rst_n || !cfg_en) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      nl_q    <= '0;
      ord_q   <= LANE_LSB_FIRST;
    end else if (src_acc) begin
      state_q <= SEND;
      hold_q  <= src_data;
      cnt_q   <= '0;
      nl_q    <= nl_d;
      ord_q   <= cfg_msb_first;
    end else if (dst_val && dst_rdy) begin
      state_q <= dst_last ? IDLE : SEND;
      cnt_q   <= dst_last ? '0 : cnt_q + 1'b1;
    end
  end
endmodule
